// File: rtl/samp_seq_pkg.sv
// Shared types and helpers for the sampling sequencer.
// Defining SAMP_SEQ_ALTERNATE_EN enables p/n chopping across conversions.
package samp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SAMPLE,
    RELEASE,
    CONVERT
  } samp_state_t;

  // Guard cycles around the sample window (SETUP before, RELEASE after).
  localparam int unsigned SETUP_GUARD   = 1;
  localparam int unsigned RELEASE_GUARD = 1;

`ifdef SAMP_SEQ_ALTERNATE_EN
  localparam bit ALT_EN = 1'b1;
`else
  localparam bit ALT_EN = 1'b0;
`endif

  // Side enables {p, n} for a conversion; odd selects the n side when chopping.
  function automatic logic [1:0] side_en(input logic p, input logic n, input logic odd);
    if (ALT_EN && p && n) return odd ? 2'b01 : 2'b10;
    return {p, n};
  endfunction

endpackage

// File: rtl/samp_seq_cnt.sv
// Loadable down-counter with zero flag, shared by SAMPLE and CONVERT timing.
module samp_seq_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/samp_seq_ctrl.sv
// Sampling sequencer: bursts of guarded sample windows for the ADC input switches.
// Optional chopping of p/n sides when SAMP_SEQ_ALTERNATE_EN is defined.
module samp_seq_ctrl
  import samp_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] samp_cycles,
  input  logic [CNT_W-1:0] conv_cycles,
  input  logic [CNT_W-1:0] num_conv,
  input  logic             p_sel,
  input  logic             n_sel,
  output logic             seq_samp,
  output logic             samp_p_en,
  output logic             samp_n_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] conv_idx
);

  samp_state_t      state;
  logic [CNT_W-1:0] samp_lat;
  logic [CNT_W-1:0] conv_lat;
  logic [CNT_W-1:0] num_lat;
  logic             p_lat;
  logic             n_lat;
  logic             abort_q;

  logic             cnt_load_c;
  logic [CNT_W-1:0] cnt_val_c;
  logic             cnt_dec_c;
  logic             cnt_zero;
  logic             abort_now_c;
  logic             last_c;
  logic             eoc_c;
  logic [CNT_W-1:0] idx_next_c;

  samp_seq_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_c),
    .load_val (cnt_val_c),
    .dec      (cnt_dec_c),
    .zero     (cnt_zero)
  );

  // Counter control and end-of-conversion decision inputs.
  always_comb begin
    cnt_load_c  = 1'b0;
    cnt_val_c   = '0;
    cnt_dec_c   = 1'b0;
    abort_now_c = abort_q | abort;
    last_c      = (num_lat != '0) && (conv_idx == (num_lat - CNT_W'(1)));
    idx_next_c  = conv_idx + CNT_W'(1);
    eoc_c       = 1'b0;
    case (state)
      SETUP: begin
        cnt_load_c = 1'b1;
        cnt_val_c  = samp_lat - CNT_W'(1);
      end
      SAMPLE:  cnt_dec_c = 1'b1;
      RELEASE: begin
        cnt_load_c = 1'b1;
        cnt_val_c  = conv_lat - CNT_W'(1);
        eoc_c      = abort_now_c || (conv_lat == '0);
      end
      CONVERT: begin
        cnt_dec_c = 1'b1;
        eoc_c     = cnt_zero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      samp_lat  <= '0;
      conv_lat  <= '0;
      num_lat   <= '0;
      p_lat     <= 1'b0;
      n_lat     <= 1'b0;
      abort_q   <= 1'b0;
      seq_samp  <= 1'b0;
      samp_p_en <= 1'b0;
      samp_n_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      conv_idx  <= '0;
    end else begin
      done <= 1'b0;
      if ((state != IDLE) && abort) abort_q <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            samp_lat <= (samp_cycles == '0) ? CNT_W'(1) : samp_cycles;
            conv_lat <= conv_cycles;
            num_lat  <= num_conv;
            p_lat    <= p_sel;
            n_lat    <= n_sel;
            conv_idx <= '0;
            busy     <= 1'b1;
            state    <= SETUP;
            {samp_p_en, samp_n_en} <= side_en(p_sel, n_sel, 1'b0);
          end
        end
        SETUP: begin
          seq_samp <= 1'b1;
          state    <= SAMPLE;
        end
        SAMPLE: begin
          if (cnt_zero) begin
            seq_samp <= 1'b0;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          if (!eoc_c) begin
            samp_p_en <= 1'b0;
            samp_n_en <= 1'b0;
            state     <= CONVERT;
          end
        end
        CONVERT: ;
        default: state <= IDLE;
      endcase

      // End of conversion: finish the burst or start the next window.
      if (eoc_c) begin
        if (abort_now_c || last_c) begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          abort_q   <= 1'b0;
          samp_p_en <= 1'b0;
          samp_n_en <= 1'b0;
        end else begin
          conv_idx <= idx_next_c;
          state    <= SETUP;
          {samp_p_en, samp_n_en} <= side_en(p_lat, n_lat, idx_next_c[0]);
        end
      end
    end
  end

endmodule
